// File: rtl/switch_counter_pkg.sv
// Shared constants, payload types and helpers for the switch counter.
package switch_counter_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 12_000_000;
  localparam int unsigned DIGIT_W          = 4;
  localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  typedef struct packed {
    logic [DIGIT_W-1:0] ms;
    logic [DIGIT_W-1:0] ls;
  } digits_t;

  // Debounce window in clk cycles, never less than one.
  function automatic int unsigned deb_cycles(input int unsigned clk_freq,
                                             input int unsigned ms);
    int unsigned n;
    n = clk_freq / 1000 * ms;
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/switch_counter_button_debounce.sv
// Raw button to single-cycle press pulse: 2-flop sync, polarity fix,
// stability counter, rising-edge pulse on the debounced level.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic        IDLE_LVL = 1'(ACTIVE_LOW);

  logic             sync1;
  logic             sync2;
  logic             level_c;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign level_c = sync2 ^ IDLE_LVL;

  // Stable only follows the synced level after DEB_CYCLES consecutive disagreements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (level_c == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      stable <= level_c;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/switch_counter.sv
// Two-digit counter driven by debounced increment and load buttons;
// counts decimal 00..99 or hex 00..FF.
module switch_counter
  import switch_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = DEFAULT_CLK_FREQ,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter bit          BCD            = 1'b1,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_inc,
  input  logic         btn_load,
  input  logic [7:0]   sw,
  output logic [3:0]   nibbleMS,
  output logic [3:0]   nibbleLS,
  output logic         changed
);

  localparam int unsigned DEB_CYCLES = deb_cycles(CLK_FREQ, DEBOUNCE_MS);

  logic    inc_p;
  logic    load_p;
  logic    upd_q;
  digits_t val_q;
  digits_t next_c;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_inc_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .press (inc_p)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_load_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_load),
    .press (load_p)
  );

  // Load wins over a coincident increment; the increment is dropped.
  always_comb begin
    next_c = val_q;
    if (load_p) begin
      if (BCD) begin
        next_c.ms = clamp_digit(sw[7:4]);
        next_c.ls = clamp_digit(sw[3:0]);
      end else begin
        next_c = sw;
      end
    end else if (inc_p) begin
      if (BCD) begin
        if (val_q.ls == BCD_DIGIT_MAX) begin
          next_c.ls = '0;
          next_c.ms = (val_q.ms == BCD_DIGIT_MAX) ? '0 : val_q.ms + DIGIT_W'(1);
        end else begin
          next_c.ls = val_q.ls + DIGIT_W'(1);
        end
      end else begin
        next_c = val_q + 8'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= '0;
      upd_q   <= 1'b0;
      changed <= 1'b0;
    end else begin
      if (inc_p || load_p) val_q <= next_c;
      upd_q   <= inc_p | load_p;
      changed <= upd_q;
    end
  end

  assign nibbleMS = val_q.ms;
  assign nibbleLS = val_q.ls;

endmodule

// File: tb/tb_switch_counter.sv
// Directed bench for switch_counter: decimal and hex instances share stimulus.
module tb_switch_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_inc;
  logic       btn_load;
  logic [7:0] sw;
  logic [3:0] ms_b, ls_b, ms_h, ls_h;
  logic       changed_b, changed_h;

  int n_checks = 0;
  int n_pass   = 0;
  int chg_cnt  = 0;
  int c0;

  always #5 clk = ~clk;

  switch_counter #(.CLK_FREQ(1000), .DEBOUNCE_MS(4), .BCD(1'b1), .BTN_ACTIVE_LOW(1'b1)) dut_bcd (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_load(btn_load), .sw(sw),
    .nibbleMS(ms_b), .nibbleLS(ls_b), .changed(changed_b)
  );

  switch_counter #(.CLK_FREQ(1000), .DEBOUNCE_MS(4), .BCD(1'b0), .BTN_ACTIVE_LOW(1'b1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_load(btn_load), .sw(sw),
    .nibbleMS(ms_h), .nibbleLS(ls_h), .changed(changed_h)
  );

  always @(negedge clk) if (changed_b === 1'b1) chg_cnt++;

  // Press (active low) for hold cycles, release, and let both debouncers settle.
  task automatic press(input logic inc, input logic ld, input int hold);
    @(posedge clk); #1;
    if (inc) btn_inc = 1'b0;
    if (ld)  btn_load = 1'b0;
    repeat (hold) @(posedge clk);
    #1 btn_inc = 1'b1; btn_load = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn_inc = 1'b1; btn_load = 1'b1; sw = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({ms_b, ls_b} !== 8'h00) $display("FAIL reset_bcd_val got %h expected 00", {ms_b, ls_b}); else n_pass++;
    n_checks++; if (changed_b !== 1'b0) $display("FAIL reset_bcd_changed got %b expected 0", changed_b); else n_pass++;
    n_checks++; if ({ms_h, ls_h} !== 8'h00) $display("FAIL reset_hex_val got %h expected 00", {ms_h, ls_h}); else n_pass++;
    n_checks++; if (changed_h !== 1'b0) $display("FAIL reset_hex_changed got %b expected 0", changed_h); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_clean_press;
    @(posedge clk); #1 btn_inc = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 7 || e == 8) begin
        n_checks++;
        if ({ms_b, ls_b} !== ((e == 8) ? 8'h01 : 8'h00))
          $display("FAIL clean_val_edge%0d got %h expected %h", e, {ms_b, ls_b}, (e == 8) ? 8'h01 : 8'h00);
        else n_pass++;
      end
      if (e >= 8) begin
        n_checks++;
        if (changed_b !== (e == 9))
          $display("FAIL clean_changed_edge%0d got %b expected %b", e, changed_b, (e == 9));
        else n_pass++;
      end
    end
    #1 btn_inc = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({ms_h, ls_h} !== 8'h01) $display("FAIL clean_hex_val got %h expected 01", {ms_h, ls_h}); else n_pass++;
  endtask

  task automatic test_bounce;
    c0 = chg_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 btn_inc = 1'b0;
      repeat (3) @(posedge clk);
      #1 btn_inc = 1'b1;
      repeat (3) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({ms_b, ls_b} !== 8'h01) $display("FAIL bounce_val got %h expected 01", {ms_b, ls_b}); else n_pass++;
    n_checks++; if (chg_cnt !== c0) $display("FAIL bounce_changed_count got %0d expected %0d", chg_cnt, c0); else n_pass++;
    press(1'b1, 1'b0, 10);
    n_checks++; if ({ms_b, ls_b} !== 8'h02) $display("FAIL hold_val got %h expected 02", {ms_b, ls_b}); else n_pass++;
    n_checks++; if (chg_cnt !== c0 + 1) $display("FAIL hold_changed_count got %0d expected %0d", chg_cnt, c0 + 1); else n_pass++;
  endtask

  task automatic test_wrap;
    sw = 8'h98;
    press(1'b0, 1'b1, 10);
    n_checks++; if ({ms_b, ls_b} !== 8'h98) $display("FAIL load98_bcd got %h expected 98", {ms_b, ls_b}); else n_pass++;
    press(1'b1, 1'b0, 10);
    n_checks++; if ({ms_b, ls_b} !== 8'h99) $display("FAIL inc_to_99 got %h expected 99", {ms_b, ls_b}); else n_pass++;
    press(1'b1, 1'b0, 10);
    n_checks++; if ({ms_b, ls_b} !== 8'h00) $display("FAIL bcd_wrap got %h expected 00", {ms_b, ls_b}); else n_pass++;
    n_checks++; if ({ms_h, ls_h} !== 8'h9A) $display("FAIL hex_9a got %h expected 9a", {ms_h, ls_h}); else n_pass++;
    sw = 8'hFF;
    press(1'b0, 1'b1, 10);
    n_checks++; if ({ms_h, ls_h} !== 8'hFF) $display("FAIL hex_load_ff got %h expected ff", {ms_h, ls_h}); else n_pass++;
    n_checks++; if ({ms_b, ls_b} !== 8'h99) $display("FAIL bcd_load_ff got %h expected 99", {ms_b, ls_b}); else n_pass++;
    press(1'b1, 1'b0, 10);
    n_checks++; if ({ms_h, ls_h} !== 8'h00) $display("FAIL hex_wrap got %h expected 00", {ms_h, ls_h}); else n_pass++;
    n_checks++; if ({ms_b, ls_b} !== 8'h00) $display("FAIL bcd_wrap2 got %h expected 00", {ms_b, ls_b}); else n_pass++;
  endtask

  task automatic test_clamp;
    sw = 8'hAF;
    press(1'b0, 1'b1, 10);
    n_checks++; if (ms_b !== 4'd9) $display("FAIL clamp_ms got %h expected 9", ms_b); else n_pass++;
    n_checks++; if (ls_b !== 4'd9) $display("FAIL clamp_ls got %h expected 9", ls_b); else n_pass++;
    n_checks++; if ({ms_h, ls_h} !== 8'hAF) $display("FAIL hex_load_af got %h expected af", {ms_h, ls_h}); else n_pass++;
  endtask

  task automatic test_back_to_back;
    sw = 8'h42;
    c0 = chg_cnt;
    press(1'b1, 1'b1, 10);
    n_checks++; if ({ms_b, ls_b} !== 8'h42) $display("FAIL simul_bcd got %h expected 42", {ms_b, ls_b}); else n_pass++;
    n_checks++; if ({ms_h, ls_h} !== 8'h42) $display("FAIL simul_hex got %h expected 42", {ms_h, ls_h}); else n_pass++;
    n_checks++; if (chg_cnt !== c0 + 1) $display("FAIL simul_changed_count got %0d expected %0d", chg_cnt, c0 + 1); else n_pass++;
    press(1'b0, 1'b1, 10);
    n_checks++; if (chg_cnt !== c0 + 2) $display("FAIL equal_load_changed got %0d expected %0d", chg_cnt, c0 + 2); else n_pass++;
    n_checks++; if ({ms_b, ls_b} !== 8'h42) $display("FAIL equal_load_val got %h expected 42", {ms_b, ls_b}); else n_pass++;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1 btn_inc = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0; btn_inc = 1'b1;
    @(negedge clk);
    n_checks++; if ({ms_b, ls_b} !== 8'h00) $display("FAIL mid_reset_val got %h expected 00", {ms_b, ls_b}); else n_pass++;
    n_checks++; if (changed_b !== 1'b0) $display("FAIL mid_reset_changed got %b expected 0", changed_b); else n_pass++;
    c0 = chg_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({ms_b, ls_b} !== 8'h00) $display("FAIL mid_release_val got %h expected 00", {ms_b, ls_b}); else n_pass++;
    n_checks++; if (chg_cnt !== c0) $display("FAIL mid_release_changed got %0d expected %0d", chg_cnt, c0); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b0; btn_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 7 || e == 8) begin
        n_checks++;
        if ({ms_b, ls_b} !== ((e == 8) ? 8'h01 : 8'h00))
          $display("FAIL held_val_edge%0d got %h expected %h", e, {ms_b, ls_b}, (e == 8) ? 8'h01 : 8'h00);
        else n_pass++;
      end
      if (e == 9) begin
        n_checks++;
        if (changed_b !== 1'b1) $display("FAIL held_changed_edge9 got %b expected 1", changed_b); else n_pass++;
      end
    end
    #1 btn_inc = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_wrap;
    test_clamp;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
